irq_pending_unit: RTL

//  Upstream feeder for the 16-input priority encoder in the rv32i interrupt path.

---
 rtl/irq_pkg.sv | 29 ++
 rtl/irq_sync.sv | 49 ++++
 rtl/irq_pending_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt pending unit: source count, ID width,
// config/read register addresses, and a one-hot helper keyed by IRQ ID.
// Pure declarations; no logic, no latency, no flow control.
package irq_pkg;

  localparam int NUM_IRQ  = 16;
  localparam int IRQ_ID_W = 4;

  // Write-side register addresses
  localparam logic [1:0] ADDR_ENABLE = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;  // 1 = edge, 0 = level
  localparam logic [1:0] ADDR_SWSET  = 2'd2;  // write-one-to-set PENDING
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;  // write-one-to-clear PENDING

  // Read-side register addresses
  localparam logic [1:0] RD_ENABLE     = 2'd0;
  localparam logic [1:0] RD_MODE       = 2'd1;
  localparam logic [1:0] RD_PENDING    = 2'd2;
  localparam logic [1:0] RD_IN_SERVICE = 2'd3;

  // One-hot mask for an IRQ ID, gated by a strobe
  function automatic logic [NUM_IRQ-1:0] id_mask(input logic en, input logic [IRQ_ID_W-1:0] id);
    logic [NUM_IRQ-1:0] m;
    m = '0;
    if (en) m[id] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-line synchroniser chain for raw IRQ inputs plus one flop for rising-edge detect.
// Latency: SYNC_STAGES cycles to sync_out; edge is combinational from sync_out/prev.
// No backpressure: free-running every cycle.
module irq_sync
  import irq_pkg::*;
#(
  parameter int WIDTH       = NUM_IRQ,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  // Shift the raw lines down the chain; remember last synced value for edges
  always_comb begin
    sync_d[0] = i_async;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Chain and edge-history flops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q[SYNC_STAGES-1];
  assign o_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_pending_unit.sv
// Holds enable/mode/pending/in-service state and presents the masked request vector.
// Latency: raw IRQ high at edge k -> PENDING at edge k+2 (SYNC_STAGES=2); outputs comb from flops.
// No backpressure: claim/complete/config writes are single-cycle strobes accepted every cycle.
module irq_pending_unit
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_IRQ-1:0]  i_irq,
  input  logic                i_wr_en,
  input  logic [1:0]          i_wr_addr,
  input  logic [NUM_IRQ-1:0]  i_wr_data,
  input  logic [1:0]          i_rd_addr,
  output logic [NUM_IRQ-1:0]  o_rd_data,
  output logic [NUM_IRQ-1:0]  o_pending_vec,
  output logic                o_irq,
  input  logic                i_claim,
  input  logic [IRQ_ID_W-1:0] i_claim_id,
  input  logic                i_complete,
  input  logic [IRQ_ID_W-1:0] i_complete_id,
  output logic                o_claim_err
);

  logic [NUM_IRQ-1:0] sync_out;
  logic [NUM_IRQ-1:0] sync_edge;

  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  logic               claim_err_q, claim_err_d;

  logic [NUM_IRQ-1:0] swset_mask;
  logic [NUM_IRQ-1:0] clear_mask;
  logic [NUM_IRQ-1:0] claim_mask;
  logic [NUM_IRQ-1:0] complete_mask;
  logic               claim_valid;

  irq_sync #(
    .WIDTH       (NUM_IRQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_irq),
    .o_sync  (sync_out),
    .o_edge  (sync_edge)
  );

  assign o_pending_vec = pending_q & enable_q & ~in_service_q;
  assign o_irq         = |o_pending_vec;
  assign o_claim_err   = claim_err_q;
  assign claim_valid   = i_claim && o_pending_vec[i_claim_id];

  // Next-state for config, pending and in-service registers
  always_comb begin
    swset_mask    = (i_wr_en && i_wr_addr == ADDR_SWSET) ? i_wr_data : '0;
    clear_mask    = (i_wr_en && i_wr_addr == ADDR_CLEAR) ? i_wr_data : '0;
    claim_mask    = id_mask(claim_valid, i_claim_id);
    complete_mask = id_mask(i_complete, i_complete_id);

    enable_d = (i_wr_en && i_wr_addr == ADDR_ENABLE) ? i_wr_data : enable_q;
    mode_d   = (i_wr_en && i_wr_addr == ADDR_MODE)   ? i_wr_data : mode_q;

    // Edge lines: set wins over clear so a fresh edge is never lost.
    // Level lines simply track the synchronised input.
    pending_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_q[i]) begin
        pending_d[i] = sync_edge[i] | swset_mask[i] |
                       (pending_q[i] & ~(claim_mask[i] | clear_mask[i]));
      end else begin
        pending_d[i] = sync_out[i];
      end
    end

    // A valid claim can never target an in-service ID, so order here is safe
    in_service_d = (in_service_q & ~complete_mask) | claim_mask;
    claim_err_d  = i_claim && !claim_valid;
  end

  // State registers; reset drops all in-service state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      enable_q     <= '0;
      mode_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      claim_err_q  <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      claim_err_q  <= claim_err_d;
    end
  end

  // Register read mux
  always_comb begin
    o_rd_data = '0;
    case (i_rd_addr)
      RD_ENABLE:     o_rd_data = enable_q;
      RD_MODE:       o_rd_data = mode_q;
      RD_PENDING:    o_rd_data = pending_q;
      RD_IN_SERVICE: o_rd_data = in_service_q;
      default:       o_rd_data = '0;
    endcase
  end

endmodule
